// File: rtl/exdeword_pkg.sv
// exdeword_pkg
//   Shared exbus transmit/receive definitions: the 2-bit word type codes held
//   in the top bits of every 35-bit bus word, the character width, and the
//   mapping from type code to the number of 7-bit characters the word
//   occupies on the serial link.  Used by the word packer, this serializer
//   and the receive-side word assembler, so all three agree on framing.
//   No ports (package).
package exdeword_pkg;

    localparam int EXB_WORD_W = 35;   // bus word width
    localparam int EXB_CHAR_W = 7;    // serial character width
    localparam int EXB_TYPE_W = 2;    // type field width, word[34:33]
    localparam int EXB_CNT_W  = 3;    // holds a character count 0..5

    // Type field codes.  IDLE also carries the special/flag words.
    localparam logic [EXB_TYPE_W-1:0] EXB_IDLE  = 2'b11;  // 1 character
    localparam logic [EXB_TYPE_W-1:0] EXB_SHORT = 2'b10;  // 2 characters
    localparam logic [EXB_TYPE_W-1:0] EXB_MID   = 2'b01;  // 3 characters
    localparam logic [EXB_TYPE_W-1:0] EXB_LONG  = 2'b00;  // 5 characters

    typedef logic [EXB_CHAR_W-1:0] exb_char_t;
    typedef logic [EXB_CNT_W-1:0]  exb_cnt_t;

    // Number of characters a word of the given type is split into.
    function automatic exb_cnt_t exb_length(input logic [EXB_TYPE_W-1:0] wtype);
        exb_cnt_t len;
        case (wtype)
            EXB_IDLE:  len = 3'd1;
            EXB_SHORT: len = 3'd2;
            EXB_MID:   len = 3'd3;
            default:   len = 3'd5;   // EXB_LONG
        endcase
        return len;
    endfunction

endpackage

// File: rtl/exdeword.sv
// exdeword
//   Byte serializer in the exbus transmit path.  Takes one 35-bit bus word
//   at a time and emits it as 1, 2, 3 or 5 seven-bit characters, most
//   significant character first, the count chosen by the word's type field.
//   A word is taken on i_stb && !o_busy; a character is taken downstream on
//   o_stb && !i_busy.  While the downstream is stalled the character and its
//   last marker hold stable, and o_stb only drops after a transfer.
//
//   Ports
//     i_clk    clock
//     i_reset  synchronous, active-high reset
//     i_stb    input word valid
//     i_word   35-bit input word, [34:33] = type field
//     i_last   word closes a transmit burst
//     o_busy   this stage cannot take i_word in the current cycle
//     o_stb    output character valid
//     o_data   output character (7 bits)
//     o_last   final character of a word that arrived with i_last
//     i_busy   downstream cannot take o_data in the current cycle
//
//   Parameter
//     OPT_LOWPOWER  when 1, o_data and o_last read as zero whenever o_stb is
//                   low (the shift register is cleared on going empty).
module exdeword
    import exdeword_pkg::*;
#(
    parameter logic OPT_LOWPOWER = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_stb,
    input  logic [EXB_WORD_W-1:0] i_word,
    input  logic                  i_last,
    output logic                  o_busy,
    output logic                  o_stb,
    output logic [EXB_CHAR_W-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_busy
);

    // The character on o_data is always the top seven bits of the shift
    // register, so o_data comes straight from flops with no extra copy.
    logic [EXB_WORD_W-1:0] sreg_q,  sreg_d;
    exb_cnt_t              nleft_q, nleft_d;   // characters still to transfer
    logic                  last_q,  last_d;    // i_last of the word in flight
    logic                  stb_q,   stb_d;
    logic                  olast_q, olast_d;

    exb_cnt_t              in_len;
    logic                  xfer;
    logic                  accept;

    assign in_len = exb_length(i_word[EXB_WORD_W-1 -: EXB_TYPE_W]);

    // o_busy is decoded from the registered count.  The i_busy term is what
    // lets the last character of one word and the first of the next share a
    // cycle: with one character left the stage is free exactly when that
    // character leaves in this cycle.  Anything more than one left is busy.
    assign o_busy = (nleft_q > 3'd1) || ((nleft_q == 3'd1) && i_busy);

    // stb_q is set exactly when nleft_q is nonzero.
    assign xfer   = stb_q && !i_busy;
    assign accept = i_stb && !o_busy;

    always_comb begin
        sreg_d  = sreg_q;
        nleft_d = nleft_q;
        last_d  = last_q;
        stb_d   = stb_q;
        olast_d = olast_q;

        if (accept) begin
            // Either the stage is empty or its final character is leaving
            // now, so loading never overwrites an untransferred character.
            sreg_d  = i_word;
            nleft_d = in_len;
            last_d  = i_last;
            stb_d   = 1'b1;
            olast_d = i_last && (in_len == 3'd1);
        end else if (xfer) begin
            if (nleft_q > 3'd1) begin
                sreg_d  = {sreg_q[EXB_WORD_W-EXB_CHAR_W-1:0], {EXB_CHAR_W{1'b0}}};
                nleft_d = nleft_q - 3'd1;
                // Two left now means the character being loaded is the final one.
                olast_d = last_q && (nleft_q == 3'd2);
            end else begin
                stb_d   = 1'b0;
                nleft_d = 3'd0;
                olast_d = 1'b0;
                if (OPT_LOWPOWER) begin
                    sreg_d = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sreg_q  <= '0;
            nleft_q <= 3'd0;
            last_q  <= 1'b0;
            stb_q   <= 1'b0;
            olast_q <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            nleft_q <= nleft_d;
            last_q  <= last_d;
            stb_q   <= stb_d;
            olast_q <= olast_d;
        end
    end

    assign o_stb  = stb_q;
    assign o_data = sreg_q[EXB_WORD_W-1 -: EXB_CHAR_W];
    assign o_last = olast_q;

endmodule

// File: tb/tb_exdeword.sv
// tb_exdeword
//   Bench for exdeword.  Two instances share the same stimulus: the default
//   build and an OPT_LOWPOWER=1 build.  The driver pushes the expected
//   character stream of each accepted word into exp_q; a monitor on the
//   falling edge pops and compares on every output transfer.
module tb_exdeword;
    import exdeword_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stb = 1'b0;
    logic [34:0] i_word = '0;
    logic        i_last = 1'b0;
    logic        i_busy = 1'b0;

    logic        o_busy, o_stb, o_last;
    logic [6:0]  o_data;
    logic        lp_busy, lp_stb, lp_last;
    logic [6:0]  lp_data;

    logic [7:0]  exp_q[$];          // {last, char} in emission order
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        busy_en = 1'b0;
    logic        mon_en  = 1'b0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_val = '0;

    exdeword #(.OPT_LOWPOWER(1'b0)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_word(i_word),
        .i_last(i_last), .o_busy(o_busy), .o_stb(o_stb), .o_data(o_data),
        .o_last(o_last), .i_busy(i_busy)
    );

    exdeword #(.OPT_LOWPOWER(1'b1)) dut_lp (
        .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_word(i_word),
        .i_last(i_last), .o_busy(lp_busy), .o_stb(lp_stb), .o_data(lp_data),
        .o_last(lp_last), .i_busy(i_busy)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // Downstream stall generator: 50% random when enabled.
    always @(posedge i_clk) begin
        #1;
        if (busy_en) i_busy = 1'($urandom_range(0, 1));
        else         i_busy = 1'b0;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference serialization: type code -> character count table, then
    // character k is the 7-bit field starting 7k bits below the top.
    task automatic push_expected(input logic [34:0] w, input logic l);
        int n;
        logic [34:0] t;
        case (w[34:33])
            2'b11:   n = 1;
            2'b10:   n = 2;
            2'b01:   n = 3;
            default: n = 5;
        endcase
        for (int k = 0; k < n; k++) begin
            t = w >> (28 - 7 * k);
            exp_q.push_back({l && (k == n - 1), t[6:0]});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [34:0] w, input logic l);
        int   guard;
        logic done;
        guard  = 0;
        done   = 1'b0;
        i_stb  = 1'b1;
        i_word = w;
        i_last = l;
        while (!done && guard < 200) begin
            @(negedge i_clk);
            done = !o_busy;
            @(posedge i_clk);
            if (done) push_expected(w, l);
            #1;
            guard++;
        end
        check("accept", {31'd0, done}, 32'd1);
        i_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        i_reset = 1'b1;
        i_stb   = 1'b0;
        repeat (cycles) @(posedge i_clk);
        #1;
        exp_q.delete();
        i_reset = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge i_clk) begin
        int         n;
        logic [7:0] head;
        if (i_reset || !mon_en) begin
            stall_prev = 1'b0;
        end else begin
            n    = exp_q.size();
            head = (n > 0) ? exp_q[0] : 8'h00;
            check("o_stb",   {31'd0, o_stb},   {31'd0, n > 0});
            check("o_busy",  {31'd0, o_busy},  {31'd0, (n > 1) || (n == 1 && i_busy)});
            check("lp_stb",  {31'd0, lp_stb},  {31'd0, n > 0});
            check("lp_busy", {31'd0, lp_busy}, {31'd0, (n > 1) || (n == 1 && i_busy)});
            if (stall_prev)
                check("hold", {23'd0, o_stb, o_last, o_data}, {23'd0, 1'b1, stall_val});
            if (!lp_stb)
                check("lp_idle", {24'd0, lp_last, lp_data}, 32'd0);
            if (o_stb && n > 0) begin
                check("char",    {24'd0, o_last, o_data},   {24'd0, head});
                check("lp_char", {24'd0, lp_last, lp_data}, {24'd0, head});
                if (!i_busy) void'(exp_q.pop_front());
            end
            stall_prev = o_stb && i_busy;
            stall_val  = {o_last, o_data};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [34:0] w;
        logic [1:0]  t;
        int          g;

        do_reset(3);
        @(negedge i_clk);
        check("rst_stb",  {31'd0, o_stb},  32'd0);
        check("rst_data", {25'd0, o_data}, 32'd0);
        check("rst_last", {31'd0, o_last}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_lp",   {23'd0, lp_stb, lp_last, lp_data}, 32'd0);
        @(posedge i_clk);
        #1;
        mon_en = 1'b1;

        // Single idle word, marked last.
        w = 35'h7F << 28;
        send_word(w, 1'b1);
        idle(3);

        // Five-character word.
        w = 35'h0_1234_5678;
        send_word(w, 1'b1);
        idle(6);

        // Back-to-back two- and three-character words.
        w = {2'b10, 33'h0_DEAD_BEEF};
        send_word(w, 1'b0);
        w = {2'b01, 33'h1_3579_2468};
        send_word(w, 1'b1);
        idle(6);

        // Reset with the second character of a five-character word showing.
        w = {2'b00, 33'h1_5A5A_A5A5};
        send_word(w, 1'b1);
        idle(1);
        do_reset(1);
        @(negedge i_clk);
        check("post_rst_stb", {31'd0, o_stb}, 32'd0);
        @(posedge i_clk);
        #1;
        w = {2'b11, 33'h0_2222_2222};
        send_word(w, 1'b0);
        idle(3);

        // Randomized mixed words under a 50% random stall.
        busy_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            t = 2'($urandom_range(0, 3));
            w = {t, 1'($urandom_range(0, 1)), 32'($urandom())};
            send_word(w, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        // Drain.
        busy_en = 1'b0;
        g = 0;
        while ((exp_q.size() != 0 || o_stb) && g < 100) begin
            @(posedge i_clk);
            #1;
            g++;
        end
        idle(2);
        check("drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #1000000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
